truth_table_sweeper: RTL and testbench

Self-checking stimulus and response stage for a 4-input combinational block (inputs x1..x4, output f). It drives all 16 input combinations in ascending order and holds each one for a programmable settle time. At the end of each hold it samples f, builds the captured truth table and compares it bit-by-bit against an expected table. Its outputs feed the combinational DUT, and its f input consumes what the DUT produces. It replaces hand-written vector lists with a reusable hardware sweep.

---
 rtl/truth_table_sweeper.sv | 122 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors of a 4-input combinational block, samples f at the end of
// each hold window, and compares the captured truth table against an expected one.
module truth_table_sweeper #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] exp_tt,
   input  logic        f,
   output logic        x1,
   output logic        x2,
   output logic        x3,
   output logic        x4,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] tt,
   output logic [4:0]  mismatch_cnt,
   output logic [3:0]  first_fail_idx,
   output logic        first_fail_valid
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  idx;
   logic [7:0]  hold_cnt;
   logic [15:0] exp_q;

   logic        hold_end;
   logic        sample_miss;
   logic [4:0]  cnt_next;

   // At most 16 misses fit in 5 bits, so the running count can never wrap.
   function automatic logic [4:0] count_miss(input logic [4:0] cnt, input logic miss);
      return cnt + {4'd0, miss};
   endfunction

   always_comb begin
      hold_end    = (hold_cnt == HOLD_LAST);
      sample_miss = f ^ exp_q[idx];
      cnt_next    = count_miss(mismatch_cnt, sample_miss);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         idx              <= 4'd0;
         hold_cnt         <= 8'd0;
         exp_q            <= 16'd0;
         {x1, x2, x3, x4} <= 4'd0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         tt               <= 16'd0;
         mismatch_cnt     <= 5'd0;
         first_fail_idx   <= 4'd0;
         first_fail_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  exp_q            <= exp_tt;
                  tt               <= 16'd0;
                  mismatch_cnt     <= 5'd0;
                  first_fail_idx   <= 4'd0;
                  first_fail_valid <= 1'b0;
                  idx              <= 4'd0;
                  hold_cnt         <= 8'd0;
                  {x1, x2, x3, x4} <= 4'd0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  state            <= SETTLE;
               end
            end

            SETTLE: begin
               // Abort wins over everything, including the final sample edge; partial results stay.
               if (abort) begin
                  state            <= IDLE;
                  busy             <= 1'b0;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  {x1, x2, x3, x4} <= 4'd0;
               end else if (!hold_end) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end else begin
                  tt[idx]      <= f;
                  mismatch_cnt <= cnt_next;
                  hold_cnt     <= 8'd0;
                  if (sample_miss && !first_fail_valid) begin
                     first_fail_idx   <= idx;
                     first_fail_valid <= 1'b1;
                  end
                  if (idx == 4'd15) begin
                     state            <= DONE;
                     busy             <= 1'b0;
                     done             <= 1'b1;
                     pass             <= (cnt_next == 5'd0);
                     {x1, x2, x3, x4} <= 4'd0;
                  end else begin
                     idx              <= idx + 4'd1;
                     {x1, x2, x3, x4} <= idx + 4'd1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with a 4-cycle hold, one with a 1-cycle hold.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic        rst = 1'b1;
   logic        start4 = 1'b0, abort4 = 1'b0;
   logic [15:0] exp4 = 16'd0;
   int          f_mode = 0;
   logic        f4;
   logic        a_x1, a_x2, a_x3, a_x4, a_busy, a_done, a_pass, a_ffv;
   logic [15:0] a_tt;
   logic [4:0]  a_mm;
   logic [3:0]  a_ffi;

   logic        start1 = 1'b0, abort1 = 1'b0;
   logic [15:0] exp1 = 16'd0;
   logic        f1;
   logic        b_x1, b_x2, b_x3, b_x4, b_busy, b_done, b_pass, b_ffv;
   logic [15:0] b_tt;
   logic [4:0]  b_mm;
   logic [3:0]  b_ffi;

   int t_start4 = 0;

   assign f4 = (f_mode == 0) ? ((a_x1 & a_x2) | a_x3) : (f_mode == 1) ? 1'b0 : 1'b1;
   assign f1 = b_x4;

   truth_table_sweeper #(.HOLD_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4), .exp_tt(exp4), .f(f4),
      .x1(a_x1), .x2(a_x2), .x3(a_x3), .x4(a_x4), .busy(a_busy), .done(a_done), .pass(a_pass),
      .tt(a_tt), .mismatch_cnt(a_mm), .first_fail_idx(a_ffi), .first_fail_valid(a_ffv)
   );

   truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .exp_tt(exp1), .f(f1),
      .x1(b_x1), .x2(b_x2), .x3(b_x3), .x4(b_x4), .busy(b_busy), .done(b_done), .pass(b_pass),
      .tt(b_tt), .mismatch_cnt(b_mm), .first_fail_idx(b_ffi), .first_fail_valid(b_ffv)
   );

   task automatic pulse_start4();
      @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      t_start4 = cyc;
   endtask

   task automatic wait_done4(output int lat);
      int n = 0;
      while (a_done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      lat = (a_done === 1'b1) ? (cyc - t_start4) : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({a_x1, a_x2, a_x3, a_x4, a_busy, a_done, a_pass, a_tt, a_mm, a_ffi, a_ffv} !== 34'd0) begin
         errors++;
         $display("FAIL reset_h4: got %h expected 0", {a_busy, a_done, a_pass, a_tt, a_mm, a_ffi, a_ffv});
      end
      checks++;
      if ({b_x1, b_x2, b_x3, b_x4, b_busy, b_done, b_pass, b_tt, b_mm, b_ffi, b_ffv} !== 34'd0) begin
         errors++;
         $display("FAIL reset_h1: got %h expected 0", {b_busy, b_done, b_pass, b_tt, b_mm, b_ffi, b_ffv});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_busy, a_done, b_busy, b_done} !== 4'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected 0000", {a_busy, a_done, b_busy, b_done});
      end
   endtask

   task automatic test_match_sweep();
      bit seq_ok = 1'b1;
      f_mode = 0;
      exp4 = 16'hFCCC;
      pulse_start4();
      for (int j = 0; j < 64; j++) begin
         if ({a_x1, a_x2, a_x3, a_x4} !== 4'(j / 4) || a_busy !== 1'b1 || a_done !== 1'b0) seq_ok = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (seq_ok !== 1'b1) begin
         errors++;
         $display("FAIL x_sequence_h4: got %b expected 1", seq_ok);
      end
      checks++;
      if (a_done !== 1'b1 || (cyc - t_start4) != 64) begin
         errors++;
         $display("FAIL done_latency_h4: got done=%b after %0d expected done=1 after 64", a_done, cyc - t_start4);
      end
      checks++;
      if ({a_tt, a_pass, a_mm, a_ffv} !== {16'hFCCC, 1'b1, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL match_result: got tt=%h pass=%b mm=%0d ffv=%b expected tt=fccc pass=1 mm=0 ffv=0",
                  a_tt, a_pass, a_mm, a_ffv);
      end
      checks++;
      if ({a_busy, a_x1, a_x2, a_x3, a_x4} !== 5'd0) begin
         errors++;
         $display("FAIL idle_outputs_in_done: got %b expected 00000", {a_busy, a_x1, a_x2, a_x3, a_x4});
      end
      @(negedge clk);
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      checks++;
      if ({a_done, a_pass} !== 2'b11) begin
         errors++;
         $display("FAIL abort_in_done_ignored: got done,pass=%b expected 11", {a_done, a_pass});
      end
   endtask

   task automatic test_single_mismatch();
      int lat;
      f_mode = 0;
      exp4 = 16'hFCCD;
      pulse_start4();
      wait_done4(lat);
      checks++;
      if (lat != 64) begin
         errors++;
         $display("FAIL mismatch_latency: got %0d expected 64", lat);
      end
      checks++;
      if ({a_tt, a_mm, a_ffi, a_ffv, a_pass} !== {16'hFCCC, 5'd1, 4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_mismatch: got tt=%h mm=%0d ffi=%0d ffv=%b pass=%b expected tt=fccc mm=1 ffi=0 ffv=1 pass=0",
                  a_tt, a_mm, a_ffi, a_ffv, a_pass);
      end
   endtask

   task automatic test_tied_outputs();
      int lat;
      f_mode = 1;
      exp4 = 16'h8000;
      pulse_start4();
      wait_done4(lat);
      checks++;
      if (lat != 64 || {a_tt, a_mm, a_ffi, a_ffv, a_pass} !== {16'h0000, 5'd1, 4'd15, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL tied_zero: got lat=%0d tt=%h mm=%0d ffi=%0d pass=%b expected lat=64 tt=0000 mm=1 ffi=15 pass=0",
                  lat, a_tt, a_mm, a_ffi, a_pass);
      end
      f_mode = 2;
      exp4 = 16'h0000;
      pulse_start4();
      checks++;
      if ({a_busy, a_done, a_tt, a_mm, a_ffv} !== {1'b1, 1'b0, 16'd0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL restart_from_done: got busy=%b done=%b tt=%h mm=%0d ffv=%b expected busy=1 done=0 tt=0 mm=0 ffv=0",
                  a_busy, a_done, a_tt, a_mm, a_ffv);
      end
      wait_done4(lat);
      checks++;
      if (lat != 64 || {a_tt, a_mm, a_ffi, a_ffv, a_pass} !== {16'hFFFF, 5'd16, 4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL tied_one: got lat=%0d tt=%h mm=%0d ffi=%0d pass=%b expected lat=64 tt=ffff mm=16 ffi=0 pass=0",
                  lat, a_tt, a_mm, a_ffi, a_pass);
      end
   endtask

   task automatic test_abort();
      int lat;
      f_mode = 0;
      exp4 = 16'hFCCC;
      pulse_start4();
      repeat (20) @(negedge clk);
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      checks++;
      if ({a_busy, a_done, a_pass, a_x1, a_x2, a_x3, a_x4} !== 7'd0) begin
         errors++;
         $display("FAIL abort_outputs: got %b expected 0000000", {a_busy, a_done, a_pass, a_x1, a_x2, a_x3, a_x4});
      end
      checks++;
      if ({a_tt, a_mm, a_ffv} !== {16'h000C, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL abort_partial_tt: got tt=%h mm=%0d ffv=%b expected tt=000c mm=0 ffv=0", a_tt, a_mm, a_ffv);
      end
      pulse_start4();
      wait_done4(lat);
      checks++;
      if (lat != 64 || {a_tt, a_pass, a_mm} !== {16'hFCCC, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL sweep_after_abort: got lat=%0d tt=%h pass=%b mm=%0d expected lat=64 tt=fccc pass=1 mm=0",
                  lat, a_tt, a_pass, a_mm);
      end
      // Abort landing on the final sample edge: no DONE, last bit never captured.
      pulse_start4();
      repeat (63) @(negedge clk);
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      checks++;
      if ({a_busy, a_done, a_pass, a_tt} !== {3'b000, 16'h7CCC}) begin
         errors++;
         $display("FAIL abort_on_final_edge: got busy=%b done=%b pass=%b tt=%h expected 0 0 0 tt=7ccc",
                  a_busy, a_done, a_pass, a_tt);
      end
   endtask

   task automatic test_ignored_start_and_reset();
      int lat;
      f_mode = 0;
      exp4 = 16'hFCCC;
      pulse_start4();
      repeat (9) @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      wait_done4(lat);
      checks++;
      if (lat != 64 || a_tt !== 16'hFCCC) begin
         errors++;
         $display("FAIL start_mid_sweep_ignored: got lat=%0d tt=%h expected lat=64 tt=fccc", lat, a_tt);
      end
      exp4 = 16'hFCCD;
      pulse_start4();
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({a_x1, a_x2, a_x3, a_x4, a_busy, a_done, a_pass, a_tt, a_mm, a_ffi, a_ffv} !== 34'd0) begin
         errors++;
         $display("FAIL reset_mid_sweep: got x=%b busy=%b done=%b tt=%h mm=%0d ffi=%0d ffv=%b expected all 0",
                  {a_x1, a_x2, a_x3, a_x4}, a_busy, a_done, a_tt, a_mm, a_ffi, a_ffv);
      end
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_mid_reset: got busy=%b expected 0", a_busy);
      end
      exp4 = 16'hFCCC;
      pulse_start4();
      repeat (10) @(negedge clk);
      start4 = 1'b1;
      abort4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      abort4 = 1'b0;
      checks++;
      if ({a_busy, a_done, a_x1, a_x2, a_x3, a_x4} !== 6'd0) begin
         errors++;
         $display("FAIL start_with_abort: got busy=%b done=%b x=%b expected busy=0 done=0 x=0000",
                  a_busy, a_done, {a_x1, a_x2, a_x3, a_x4});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin
         errors++;
         $display("FAIL stays_idle_after_abort: got busy=%b expected 0", a_busy);
      end
   endtask

   task automatic test_hold_one();
      bit seq_ok = 1'b1;
      int t0;
      exp1 = 16'hAAAA;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      t0 = cyc;
      for (int j = 0; j < 16; j++) begin
         if ({b_x1, b_x2, b_x3, b_x4} !== 4'(j) || b_busy !== 1'b1 || b_done !== 1'b0) seq_ok = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (seq_ok !== 1'b1) begin
         errors++;
         $display("FAIL x_sequence_h1: got %b expected 1", seq_ok);
      end
      checks++;
      if (b_done !== 1'b1 || (cyc - t0) != 16) begin
         errors++;
         $display("FAIL done_latency_h1: got done=%b after %0d expected done=1 after 16", b_done, cyc - t0);
      end
      checks++;
      if ({b_tt, b_pass, b_mm, b_ffi, b_ffv} !== {16'hAAAA, 1'b1, 5'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL hold_one_result: got tt=%h pass=%b mm=%0d ffi=%0d ffv=%b expected tt=aaaa pass=1 mm=0 ffi=0 ffv=0",
                  b_tt, b_pass, b_mm, b_ffi, b_ffv);
      end
   endtask

   initial begin
      test_reset();
      test_match_sweep();
      test_single_mismatch();
      test_tied_outputs();
      test_abort();
      test_ignored_start_and_reset();
      test_hold_one();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
